// File: rtl/xup_vector_serializer.sv
// Parallel-to-serial converter: accepts a SIZE-bit word over valid/ready and
// shifts it out one bit at a time, holding each bit for BIT_CYCLES clocks.
module xup_vector_serializer #(
    parameter int SIZE       = 8,
    parameter int BIT_CYCLES = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [SIZE-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic            abort,
    output logic            sout,
    output logic            sout_valid,
    output logic            sout_last,
    output logic            busy
);

    // Handshake: a word transfers on a rising edge where din_valid && din_ready;
    // din_ready is high only in IDLE, so no word is taken while one is in flight.

    localparam int BIT_W = ($clog2(SIZE) < 1) ? 1 : $clog2(SIZE);
    localparam int CYC_W = ($clog2(BIT_CYCLES) < 1) ? 1 : $clog2(BIT_CYCLES);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              sout_last_q, sout_last_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless here; a word offered now is still taken
                if (din_valid) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                end else if (cyc_cnt_q == CYC_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_IDLE;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[SIZE-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[SIZE-1:1]};
                        end
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial outputs are registered from the next-state view so the first bit
    // is on sout in the cycle right after acceptance.
    always_comb begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
        if (state_d == ST_SHIFT) begin
            sout_d       = MSB_FIRST ? shreg_d[SIZE-1] : shreg_d[0];
            sout_valid_d = 1'b1;
            sout_last_d  = (bit_cnt_d == BIT_LAST);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign din_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;

endmodule
